// File: rtl/shift_request_seq.sv
// Request sequencer for a combinational barrel shifter. Requests are queued in a small FIFO
// and issued one amount per clock, or all eight amounts when a sweep is requested.
module shift_request_seq #(
    parameter int DEPTH = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       in_valid,
    output logic       in_ready,
    input  logic [7:0] in_data,
    input  logic [2:0] in_amt,
    input  logic       in_sweep,
    output logic [7:0] sh_data,
    output logic [2:0] sh_amt,
    input  logic [7:0] sh_out,
    output logic       out_valid,
    input  logic       out_ready,
    output logic [7:0] out_data,
    output logic [2:0] out_amt,
    output logic       out_last,
    output logic       busy
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    typedef enum logic {
        ST_IDLE,
        ST_RUN
    } state_t;

    state_t          r_state;
    state_t          w_next_state;

    logic [11:0]     r_mem [DEPTH];
    logic [AW-1:0]   r_wr_ptr;
    logic [AW-1:0]   r_rd_ptr;
    logic [CW-1:0]   r_count;

    logic [7:0]      r_cur_data;
    logic [2:0]      r_cur_amt;
    logic            r_cur_sweep;

    logic            r_out_valid;
    logic [7:0]      r_out_data;
    logic [2:0]      r_out_amt;
    logic            r_out_last;

    logic            w_full;
    logic            w_empty;
    logic            w_push;
    logic            w_pop;
    logic            w_capture;
    logic            w_last;
    logic [11:0]     w_head;

    assign w_full   = (r_count == CW'(DEPTH));
    assign w_empty  = (r_count == '0);
    // No pass-through: a pop in the same cycle does not open a slot for the offered request.
    assign in_ready = !w_full;
    assign w_push   = in_valid && !w_full;
    assign w_head   = r_mem[r_rd_ptr];

    // NOTE: every output of a combinational block gets a default first, so no path infers a latch.
    always_comb begin
        w_next_state = r_state;
        w_pop        = 1'b0;
        w_capture    = 1'b0;
        w_last       = !r_cur_sweep || (r_cur_amt == 3'd7);
        case (r_state)
            ST_IDLE: begin
                if (!w_empty) begin
                    w_pop        = 1'b1;
                    w_next_state = ST_RUN;
                end
            end
            ST_RUN: begin
                if (!r_out_valid || out_ready) begin
                    w_capture = 1'b1;
                    if (w_last) begin
                        if (!w_empty) begin
                            w_pop = 1'b1;
                        end else begin
                            w_next_state = ST_IDLE;
                        end
                    end
                end
            end
            default: w_next_state = ST_IDLE;
        endcase
    end

    // NOTE: sequential state is updated with non-blocking assignments only.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // NOTE: the storage array is not reset; the pointers and count alone define which entries are valid.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= {in_data, in_amt, in_sweep};
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + AW'(1);
            if (w_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + CW'(1);
                2'b01:   r_count <= r_count - CW'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    // A non-last capture is always a sweep below amount 7, so the increment cannot wrap.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cur_data  <= '0;
            r_cur_amt   <= '0;
            r_cur_sweep <= 1'b0;
        end else if (w_pop) begin
            r_cur_data  <= w_head[11:4];
            r_cur_amt   <= w_head[0] ? 3'd0 : w_head[3:1];
            r_cur_sweep <= w_head[0];
        end else if (w_capture && !w_last) begin
            r_cur_amt   <= r_cur_amt + 3'd1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_out_valid <= 1'b0;
            r_out_data  <= '0;
            r_out_amt   <= '0;
            r_out_last  <= 1'b0;
        end else if (w_capture) begin
            r_out_valid <= 1'b1;
            r_out_data  <= sh_out;
            r_out_amt   <= r_cur_amt;
            r_out_last  <= w_last;
        end else if (out_ready) begin
            r_out_valid <= 1'b0;
        end
    end

    assign sh_data   = r_cur_data;
    assign sh_amt    = r_cur_amt;
    assign out_valid = r_out_valid;
    assign out_data  = r_out_data;
    assign out_amt   = r_out_amt;
    assign out_last  = r_out_last;
    assign busy      = !w_empty || (r_state == ST_RUN) || r_out_valid;

endmodule

// File: tb/tb_shift_request_seq.sv
// Directed bench for shift_request_seq; the barrel shifter is replaced by sh_out = sh_data + sh_amt.
module tb_shift_request_seq;

    localparam int DEPTH = 4;

    logic       clk = 1'b0;
    logic       rst;
    logic       in_valid;
    logic       in_ready;
    logic [7:0] in_data;
    logic [2:0] in_amt;
    logic       in_sweep;
    logic [7:0] sh_data;
    logic [2:0] sh_amt;
    logic [7:0] sh_out;
    logic       out_valid;
    logic       out_ready;
    logic [7:0] out_data;
    logic [2:0] out_amt;
    logic       out_last;
    logic       busy;

    int total = 0;
    int bad   = 0;

    shift_request_seq #(.DEPTH(DEPTH)) dut (
        .clk      (clk),
        .rst      (rst),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .in_data  (in_data),
        .in_amt   (in_amt),
        .in_sweep (in_sweep),
        .sh_data  (sh_data),
        .sh_amt   (sh_amt),
        .sh_out   (sh_out),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_data (out_data),
        .out_amt  (out_amt),
        .out_last (out_last),
        .busy     (busy)
    );

    assign sh_out = sh_data + {5'b0, sh_amt};

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        total++;
        assert (observed === expected) else begin
            bad++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic offer(input logic [7:0] d, input logic [2:0] a, input logic s);
        in_valid = 1'b1;
        in_data  = d;
        in_amt   = a;
        in_sweep = s;
    endtask

    task automatic check_out(input string tag, input logic [7:0] d, input logic [2:0] a, input logic l);
        check({tag, "_valid"}, out_valid, 1'b1);
        check({tag, "_data"},  out_data,  d);
        check({tag, "_amt"},   out_amt,   a);
        check({tag, "_last"},  out_last,  l);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int accepted;
        rst       = 1'b1;
        in_valid  = 1'b0;
        in_data   = '0;
        in_amt    = '0;
        in_sweep  = 1'b0;
        out_ready = 1'b1;

        // Reset state, observed before any clock edge.
        #3;
        check("rst_in_ready",  in_ready,  1'b1);
        check("rst_out_valid", out_valid, 1'b0);
        check("rst_busy",      busy,      1'b0);
        check("rst_sh_data",   sh_data,   8'h00);
        check("rst_sh_amt",    sh_amt,    3'd0);
        check("rst_out_data",  out_data,  8'h00);
        check("rst_out_last",  out_last,  1'b0);
        step();
        step();
        rst = 1'b0;

        // Single request: 0x55 + 3 = 0x58 two clocks after acceptance.
        offer(8'h55, 3'd3, 1'b0);
        step();
        in_valid = 1'b0;
        check("single_lat1_valid", out_valid, 1'b0);
        check("single_busy", busy, 1'b1);
        step();
        check("single_lat2_valid", out_valid, 1'b0);
        check("single_sh_data", sh_data, 8'h55);
        check("single_sh_amt",  sh_amt,  3'd3);
        step();
        check_out("single", 8'h58, 3'd3, 1'b1);
        step();
        check("single_clear", out_valid, 1'b0);
        check("single_idle_busy", busy, 1'b0);
        check("single_hold_sh_data", sh_data, 8'h55);

        // Sweep of 0xCC: eight consecutive results, last only at amount 7.
        offer(8'hCC, 3'd5, 1'b1);
        step();
        in_valid = 1'b0;
        step();
        for (int i = 0; i < 8; i++) begin
            logic [7:0] d;
            d = 8'hCC + 8'(i);
            step();
            check_out("sweep", d, 3'(i), (i == 7));
        end
        step();
        check("sweep_clear", out_valid, 1'b0);

        // Backpressure: stall three cycles on amount 2, then 3..7 follow.
        offer(8'h01, 3'd0, 1'b1);
        step();
        in_valid = 1'b0;
        step();
        for (int i = 0; i < 3; i++) begin
            logic [7:0] d;
            d = 8'h01 + 8'(i);
            step();
            check_out("bp_pre", d, 3'(i), 1'b0);
        end
        out_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step();
            check_out("bp_stall", 8'h03, 3'd2, 1'b0);
        end
        out_ready = 1'b1;
        for (int i = 3; i < 8; i++) begin
            logic [7:0] d;
            d = 8'h01 + 8'(i);
            step();
            check_out("bp_post", d, 3'(i), (i == 7));
        end
        step();
        check("bp_clear", out_valid, 1'b0);

        // Back-to-back single requests, one result per clock.
        offer(8'h01, 3'd0, 1'b0);
        step();
        offer(8'h01, 3'd1, 1'b0);
        step();
        check("b2b_lat_valid", out_valid, 1'b0);
        offer(8'h01, 3'd2, 1'b0);
        step();
        in_valid = 1'b0;
        check_out("b2b_0", 8'h01, 3'd0, 1'b1);
        step();
        check_out("b2b_1", 8'h02, 3'd1, 1'b1);
        step();
        check_out("b2b_2", 8'h03, 3'd2, 1'b1);
        step();
        check("b2b_clear", out_valid, 1'b0);

        // Fill with the consumer stalled: DEPTH in the FIFO, one working, one held at the output.
        out_ready = 1'b0;
        accepted  = 0;
        for (int i = 0; i < DEPTH + 3; i++) begin
            logic [7:0] d;
            d = 8'h20 + 8'(i);
            offer(d, 3'(i), 1'b0);
            if (in_ready) accepted++;
            step();
        end
        in_valid = 1'b0;
        check("fill_accepted", 32'(accepted), 32'(DEPTH + 2));
        check("fill_in_ready", in_ready, 1'b0);
        out_ready = 1'b1;
        for (int k = 0; k < DEPTH + 2; k++) begin
            logic [7:0] d;
            d = 8'h20 + 8'(2 * k);
            check_out("drain", d, 3'(k), 1'b1);
            step();
        end
        check("drain_clear", out_valid, 1'b0);
        check("drain_busy", busy, 1'b0);
        check("drain_in_ready", in_ready, 1'b1);

        // Reset in the middle of a sweep, then a normal request afterwards.
        offer(8'h40, 3'd0, 1'b1);
        step();
        in_valid = 1'b0;
        step();
        for (int i = 0; i < 5; i++) step();
        check_out("mid_sweep", 8'h44, 3'd4, 1'b0);
        #2;
        rst = 1'b1;
        #1;
        check("arst_out_valid", out_valid, 1'b0);
        check("arst_busy",      busy,      1'b0);
        check("arst_in_ready",  in_ready,  1'b1);
        check("arst_sh_data",   sh_data,   8'h00);
        check("arst_out_amt",   out_amt,   3'd0);
        step();
        step();
        rst = 1'b0;
        offer(8'h10, 3'd1, 1'b0);
        step();
        in_valid = 1'b0;
        step();
        step();
        check_out("post_rst", 8'h11, 3'd1, 1'b1);
        step();
        check("post_rst_clear", out_valid, 1'b0);
        check("post_rst_busy", busy, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/shift_request_seq.md
SHIFT_REQUEST_SEQ -- requirements
Module: shift_request_seq

Interface
REQ-001 SHALL have parameter DEPTH, default 4: request FIFO entries, a power of 2 and at least 2.
REQ-002 SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-003 SHALL have port rst, input, 1 bit: reset, asynchronous and active-high.
REQ-004 SHALL have port in_valid, input, 1 bit: a request is offered.
REQ-005 SHALL have port in_ready, output, 1 bit: the block can accept a request.
REQ-006 SHALL have port in_data, input, 8 bits: the data word to shift.
REQ-007 SHALL have port in_amt, input, 3 bits: the shift amount; ignored when in_sweep=1.
REQ-008 SHALL have port in_sweep, input, 1 bit: 1 issues all amounts 0..7 for in_data.
REQ-009 SHALL have port sh_data, output, 8 bits: data driven to the downstream barrel_shifter.
REQ-010 SHALL have port sh_amt, output, 3 bits: amount driven to the barrel_shifter.
REQ-011 SHALL have port sh_out, input, 8 bits: combinational result returned by the barrel_shifter.
REQ-012 SHALL have port out_valid, output, 1 bit: a result is held.
REQ-013 SHALL have port out_ready, input, 1 bit: the consumer accepts the result.
REQ-014 SHALL have port out_data, output, 8 bits: the captured sh_out.
REQ-015 SHALL have port out_amt, output, 3 bits: the amount that produced out_data.
REQ-016 SHALL have port out_last, output, 1 bit: final result of its request.
REQ-017 SHALL have port busy, output, 1 bit: FIFO non-empty, state RUN, or out_valid=1.

Function
REQ-018 SHALL push {in_data, in_amt, in_sweep} into the FIFO on every edge where in_valid and in_ready are both 1.
REQ-019 SHALL drive in_ready = FIFO not full; no pass-through, so in_ready stays 0 when full even if a pop occurs that cycle.
REQ-020 SHALL keep an internal FIFO count of width $clog2(DEPTH)+1; read and write pointers wrap modulo DEPTH.
REQ-021 SHALL implement the FSM IDLE -> RUN: in IDLE with the FIFO non-empty, pop the head into working registers cur_data, cur_amt (0 if sweep, else the stored amount) and cur_sweep, then enter RUN.
REQ-022 SHALL drive sh_data=cur_data and sh_amt=cur_amt directly from the working registers; they hold their values in IDLE.
REQ-023 SHALL capture in RUN when out_valid=0 or out_ready=1: out_data<=sh_out, out_amt<=cur_amt, out_last<=(!cur_sweep || cur_amt==7), out_valid<=1.
REQ-024 SHALL, on a capture that is not last, increment cur_amt by 1 and stay in RUN; the count never wraps past 7.
REQ-025 SHALL, on a last capture, pop the next request into the working registers and stay in RUN if the FIFO is non-empty, else go to IDLE, giving one result per clock sustained.
REQ-026 SHALL, when out_valid=1 and out_ready=0, hold out_* and stall RUN with cur_amt unchanged; no amount is skipped or repeated.
REQ-027 SHALL clear out_valid on an edge with out_ready=1 and no new capture.
REQ-028 SHALL produce latency of 2 clocks, from the accepting edge to out_valid=1, for a request into an empty, idle block.

Reset
REQ-029 SHALL, while rst=1 and regardless of clk, set state IDLE, FIFO pointers and count 0, and cur_data, cur_amt, cur_sweep 0.
REQ-030 SHALL, while rst=1, drive sh_data, sh_amt, out_data, out_amt, out_last, out_valid and busy to 0 and in_ready to 1.
REQ-031 SHALL discard any in-flight sweep or queued request on reset; the first request accepted after release is processed normally.

Verification
Bench stub for all scenarios: sh_out = sh_data + sh_amt (mod 256).
REQ-032 SHALL cover a single request: data 0x55, amt 3, sweep 0, out_ready 1 -> 2 clocks later out_data 0x58, out_amt 3, out_last 1, out_valid for 1 cycle.
REQ-033 SHALL cover a sweep: data 0xCC, sweep 1, out_ready 1 -> out_data 0xCC..0xD3 and out_amt 0..7 on 8 consecutive cycles, out_last only with amt 7.
REQ-034 SHALL cover backpressure: the sweep of 0x01 with out_ready 0 for 3 cycles while out_amt=2 -> out_data 0x03 stable, then amts 3..7 follow with none skipped.
REQ-035 SHALL cover back-to-back requests: data 0x01 with amts 0, 1, 2 pushed on consecutive cycles -> out_data 0x01, 0x02, 0x03 on consecutive cycles, each with out_last 1.
REQ-036 SHALL cover fill: out_ready 0 and DEPTH+3 non-sweep pushes -> exactly DEPTH+2 accepted, then in_ready 0; after draining, results come out in push order.
REQ-037 SHALL cover reset mid-sweep: rst asserted while out_amt=4 -> out_valid 0, busy 0, in_ready 1 with no clock edge; after release, a new request for 0x10 amt 1 yields 0x11.
